// File: rtl/img2col_unit.sv
`default_nettype none
// ============================================================================
// Module   : img2col_unit
// Brief    : Image-to-column address generator and window gatherer. Walks
//            the output positions of a convolution layer, issues one kernel
//            tap per cycle as SIZE per-lane reads toward the IFM buffer
//            bridge, and registers the returned pixels as a column vector.
// Options  : I2C_PAD_EN - when defined, cfg_pad requests 1-pixel zero padding.
// Revision : 1.0 - initial release
// ============================================================================
module img2col_unit #(
  parameter int SIZE   = 8,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   start,
  input  logic [7:0]             cfg_iw,
  input  logic [7:0]             cfg_ih,
  input  logic [2:0]             cfg_k,
  input  logic [1:0]             cfg_s,
  input  logic                   cfg_pad,
  input  logic                   hold,
  output logic [SIZE-1:0]        ifm_rd_en_i2c,
  output logic [SIZE*ADDR_W-1:0] ifm_rd_addr_i2c,
  input  logic [SIZE*DATA_W-1:0] pixel_2_i2c,
  output logic [SIZE*DATA_W-1:0] col_data,
  output logic                   col_valid,
  output logic [SIZE-1:0]        col_lane_mask,
  output logic                   col_last,
  output logic                   busy,
  output logic                   done
);

  // Signed width for pixel coordinates; covers -1 .. 3*256+6.
  localparam int         XW     = 12;
  localparam logic [9:0] SIZE_C = 10'(SIZE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Integer floor division by the stride (1..3).
  function automatic logic [8:0] div_by_s(input logic [8:0] n, input logic [1:0] s);
    case (s)
      2'd2:    return n >> 1;
      2'd3:    return n / 9'd3;
      default: return n;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Start-time configuration decode
  // ---------------------------------------------------------------------------
  logic pad_w;
`ifdef I2C_PAD_EN
  assign pad_w = cfg_pad;
`else
  // Padding is not built in: the request bit is read but has no effect.
  assign pad_w = cfg_pad & 1'b0;
`endif

  logic [8:0]              ext_iw_w, ext_ih_w, span_w_w, span_h_w, ow_w, oh_w;
  logic                    cfg_bad_w;
  logic [ADDR_W-1:0]       siw_w, yorg_addr_w;
  logic signed [XW-1:0]    xstep_w, org_w;

  assign ext_iw_w    = {1'b0, cfg_iw} + {7'd0, pad_w, 1'b0};
  assign ext_ih_w    = {1'b0, cfg_ih} + {7'd0, pad_w, 1'b0};
  assign cfg_bad_w   = (cfg_k == 3'd0) || (cfg_s == 2'd0) ||
                       ({6'd0, cfg_k} > ext_iw_w) || ({6'd0, cfg_k} > ext_ih_w);
  assign span_w_w    = ext_iw_w - {6'd0, cfg_k};
  assign span_h_w    = ext_ih_w - {6'd0, cfg_k};
  assign ow_w        = div_by_s(span_w_w, cfg_s) + 9'd1;
  assign oh_w        = div_by_s(span_h_w, cfg_s) + 9'd1;
  // Row-address step per output row and column-base step per tile; both are
  // formed once per layer so the issue path only adds.
  assign siw_w       = ADDR_W'(cfg_iw) * ADDR_W'(cfg_s);
  assign xstep_w     = XW'(SIZE) * XW'(cfg_s);
  assign org_w       = {XW{pad_w}};
  assign yorg_addr_w = pad_w ? (ADDR_W'(0) - ADDR_W'(cfg_iw)) : ADDR_W'(0);

  // ---------------------------------------------------------------------------
  // State and loop counters
  // ---------------------------------------------------------------------------
  state_t               state_q;
  logic                 busy_q, done_q;
  logic [7:0]           iw_q, ih_q;
  logic [2:0]           k_q, kx_q, ky_q;
  logic [1:0]           s_q;
  logic [8:0]           ow_q, oh_q, ox_q, oy_q;
  logic signed [XW-1:0] xorg_q, xstep_q, xbase_q, ybase_q, y_q;
  logic signed [XW-1:0] lane_off_q [SIZE];
  logic [ADDR_W-1:0]    siw_q, ybase_addr_q, yaddr_q;

  logic issue_w, last_kx_w, last_ky_w, last_ox_w, last_oy_w, final_w, y_in_w;

  assign issue_w   = (state_q == ST_RUN) && !hold;
  assign last_kx_w = (kx_q == k_q - 3'd1);
  assign last_ky_w = (ky_q == k_q - 3'd1);
  assign last_ox_w = ({1'b0, ox_q} + SIZE_C) >= {1'b0, ow_q};
  assign last_oy_w = (oy_q == oh_q - 9'd1);
  assign final_w   = last_kx_w && last_ky_w && last_ox_w && last_oy_w;
  assign y_in_w    = !y_q[XW-1] && (y_q < $signed({{(XW-8){1'b0}}, ih_q}));

  // ---------------------------------------------------------------------------
  // Per-lane coordinate, bounds and address generation
  // ---------------------------------------------------------------------------
  logic [SIZE-1:0] en_w, mask_w;

  generate
    for (genvar b = 0; b < SIZE; b++) begin : g_lane
      logic signed [XW-1:0] x_w;
      logic                 x_in_w;
      assign x_w       = xbase_q + lane_off_q[b] + XW'(kx_q);
      assign x_in_w    = !x_w[XW-1] && (x_w < $signed({{(XW-8){1'b0}}, iw_q}));
      assign mask_w[b] = ({1'b0, ox_q} + 10'(b)) < {1'b0, ow_q};
      assign en_w[b]   = issue_w && mask_w[b] && x_in_w && y_in_w;
      assign ifm_rd_addr_i2c[b*ADDR_W +: ADDR_W] =
          en_w[b] ? (yaddr_q + ADDR_W'(x_w)) : '0;
    end
  endgenerate

  assign ifm_rd_en_i2c = en_w;

  // ---------------------------------------------------------------------------
  // Return pipeline: stage 1 tracks the read in flight, stage 2 is the column
  // ---------------------------------------------------------------------------
  logic                   v1_q, last1_q;
  logic [SIZE-1:0]        en1_q, mask1_q;
  logic                   col_valid_q, col_last_q;
  logic [SIZE-1:0]        col_mask_q;
  logic [SIZE*DATA_W-1:0] col_data_q;

  // FSM, configuration latch and tap loop counters (kx innermost, then ky, ox, oy).
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      iw_q         <= '0;
      ih_q         <= '0;
      k_q          <= '0;
      s_q          <= '0;
      ow_q         <= '0;
      oh_q         <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      ox_q         <= '0;
      oy_q         <= '0;
      xorg_q       <= '0;
      xstep_q      <= '0;
      xbase_q      <= '0;
      ybase_q      <= '0;
      y_q          <= '0;
      siw_q        <= '0;
      ybase_addr_q <= '0;
      yaddr_q      <= '0;
      for (int b = 0; b < SIZE; b++) lane_off_q[b] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (cfg_bad_w) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q      <= ST_RUN;
              iw_q         <= cfg_iw;
              ih_q         <= cfg_ih;
              k_q          <= cfg_k;
              s_q          <= cfg_s;
              ow_q         <= ow_w;
              oh_q         <= oh_w;
              kx_q         <= '0;
              ky_q         <= '0;
              ox_q         <= '0;
              oy_q         <= '0;
              xorg_q       <= org_w;
              xstep_q      <= xstep_w;
              xbase_q      <= org_w;
              ybase_q      <= org_w;
              y_q          <= org_w;
              siw_q        <= siw_w;
              ybase_addr_q <= yorg_addr_w;
              yaddr_q      <= yorg_addr_w;
              for (int b = 0; b < SIZE; b++) lane_off_q[b] <= XW'(b) * XW'(cfg_s);
            end
          end
        end
        ST_RUN: begin
          if (issue_w) begin
            if (!last_kx_w) begin
              kx_q <= kx_q + 3'd1;
            end else begin
              kx_q <= '0;
              if (!last_ky_w) begin
                ky_q    <= ky_q + 3'd1;
                y_q     <= y_q + XW'(1);
                yaddr_q <= yaddr_q + ADDR_W'(iw_q);
              end else begin
                ky_q    <= '0;
                y_q     <= ybase_q;
                yaddr_q <= ybase_addr_q;
                if (!last_ox_w) begin
                  ox_q    <= ox_q + 9'(SIZE);
                  xbase_q <= xbase_q + xstep_q;
                end else begin
                  ox_q    <= '0;
                  xbase_q <= xorg_q;
                  if (!last_oy_w) begin
                    oy_q         <= oy_q + 9'd1;
                    ybase_q      <= ybase_q + XW'(s_q);
                    y_q          <= ybase_q + XW'(s_q);
                    ybase_addr_q <= ybase_addr_q + siw_q;
                    yaddr_q      <= ybase_addr_q + siw_q;
                  end else begin
                    state_q <= ST_DRAIN;
                  end
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (last1_q) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Delay issue qualifiers by one cycle and register returned pixels, zeroing disabled lanes.
  always_ff @(posedge clock) begin
    if (rst) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      en1_q       <= '0;
      mask1_q     <= '0;
      col_valid_q <= 1'b0;
      col_last_q  <= 1'b0;
      col_mask_q  <= '0;
      col_data_q  <= '0;
    end else begin
      v1_q        <= issue_w;
      last1_q     <= issue_w && final_w;
      en1_q       <= en_w;
      mask1_q     <= issue_w ? mask_w : '0;
      col_valid_q <= v1_q;
      col_last_q  <= last1_q;
      col_mask_q  <= mask1_q;
      for (int b = 0; b < SIZE; b++) begin
        col_data_q[b*DATA_W +: DATA_W] <= en1_q[b] ? pixel_2_i2c[b*DATA_W +: DATA_W] : '0;
      end
    end
  end

  assign col_data      = col_data_q;
  assign col_valid     = col_valid_q;
  assign col_lane_mask = col_mask_q;
  assign col_last      = col_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_img2col_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_img2col_unit
// Brief    : Directed self-checking bench for img2col_unit. A bridge model
//            returns a lane/address tagged pixel one cycle after each read;
//            every cycle of a layer is logged and checked against hand values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_img2col_unit;

  localparam int SIZE   = 8;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 128;
  localparam int LOGN   = 64;

  logic                   clock;
  logic                   rst;
  logic                   start;
  logic [7:0]             cfg_iw;
  logic [7:0]             cfg_ih;
  logic [2:0]             cfg_k;
  logic [1:0]             cfg_s;
  logic                   cfg_pad;
  logic                   hold;
  logic [SIZE-1:0]        ifm_rd_en_i2c;
  logic [SIZE*ADDR_W-1:0] ifm_rd_addr_i2c;
  logic [SIZE*DATA_W-1:0] pixel_2_i2c;
  logic [SIZE*DATA_W-1:0] col_data;
  logic                   col_valid;
  logic [SIZE-1:0]        col_lane_mask;
  logic                   col_last;
  logic                   busy;
  logic                   done;

  img2col_unit #(.SIZE(SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock           (clock),
    .rst             (rst),
    .start           (start),
    .cfg_iw          (cfg_iw),
    .cfg_ih          (cfg_ih),
    .cfg_k           (cfg_k),
    .cfg_s           (cfg_s),
    .cfg_pad         (cfg_pad),
    .hold            (hold),
    .ifm_rd_en_i2c   (ifm_rd_en_i2c),
    .ifm_rd_addr_i2c (ifm_rd_addr_i2c),
    .pixel_2_i2c     (pixel_2_i2c),
    .col_data        (col_data),
    .col_valid       (col_valid),
    .col_lane_mask   (col_lane_mask),
    .col_last        (col_last),
    .busy            (busy),
    .done            (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Per-cycle log of one layer; cycle 0 is the start cycle.
  logic [SIZE-1:0]        rd_log [LOGN];
  logic [SIZE*ADDR_W-1:0] ad_log [LOGN];
  logic [SIZE*DATA_W-1:0] cd_log [LOGN];
  logic [SIZE-1:0]        cm_log [LOGN];
  logic                   cv_log [LOGN];
  logic                   cl_log [LOGN];
  logic                   dn_log [LOGN];
  logic                   bz_log [LOGN];
  int                     done_cyc;
  int                     n_assert;
  int                     n_fail;
  logic [SIZE-1:0]        prev_en;
  logic [SIZE*ADDR_W-1:0] prev_addr;

  function automatic logic [DATA_W-1:0] pix(input int b, input int a);
    logic [DATA_W-1:0] v;
    v = '0;
    v[31:0] = {8'hA5, 8'(b), 6'd0, 10'(a)};
    return v;
  endfunction

  function automatic int addr_at(input int c, input int b);
    logic [SIZE*ADDR_W-1:0] w;
    w = ad_log[c];
    return int'(w[b*ADDR_W +: ADDR_W]);
  endfunction

  function automatic logic [DATA_W-1:0] data_at(input int c, input int b);
    logic [SIZE*DATA_W-1:0] w;
    w = cd_log[c];
    return w[b*DATA_W +: DATA_W];
  endfunction

  function automatic int count_cv();
    int n = 0;
    for (int i = 0; i < LOGN; i++) if (cv_log[i]) n++;
    return n;
  endfunction

  function automatic int count_rd();
    int n = 0;
    for (int i = 0; i < LOGN; i++) if (rd_log[i] != '0) n++;
    return n;
  endfunction

  // Runs one layer from its start cycle until done (or a reset/cycle budget).
  // After cycle 0 the cfg inputs carry unrelated values, and an optional
  // second start pulse is driven while the layer is busy.
  task automatic run_layer(input int iw, input int ih, input int k, input int s,
                           input int pad, input int hold_at, input int hold_len,
                           input int restart_at, input int rst_at);
    done_cyc = -1;
    for (int i = 0; i < LOGN; i++) begin
      rd_log[i] = '0; ad_log[i] = '0; cd_log[i] = '0; cm_log[i] = '0;
      cv_log[i] = 1'b0; cl_log[i] = 1'b0; dn_log[i] = 1'b0; bz_log[i] = 1'b0;
    end
    for (int cyc = 0; cyc < LOGN; cyc++) begin
      @(negedge clock);
      for (int b = 0; b < SIZE; b++) begin
        pixel_2_i2c[b*DATA_W +: DATA_W] = prev_en[b] ?
            pix(b, int'(prev_addr[b*ADDR_W +: ADDR_W])) : {DATA_W{1'b1}};
      end
      if (cyc == 0) begin
        start = 1'b1; cfg_iw = 8'(iw); cfg_ih = 8'(ih);
        cfg_k = 3'(k); cfg_s = 2'(s); cfg_pad = pad[0];
      end else begin
        start = (cyc == restart_at);
        cfg_iw = 8'd10; cfg_ih = 8'd1; cfg_k = 3'd1; cfg_s = 2'd1; cfg_pad = 1'b0;
      end
      hold = (cyc >= hold_at) && (cyc < hold_at + hold_len);
      rst  = (cyc == rst_at);
      #1;
      rd_log[cyc] = ifm_rd_en_i2c;   ad_log[cyc] = ifm_rd_addr_i2c;
      cd_log[cyc] = col_data;        cm_log[cyc] = col_lane_mask;
      cv_log[cyc] = col_valid;       cl_log[cyc] = col_last;
      dn_log[cyc] = done;            bz_log[cyc] = busy;
      prev_en = ifm_rd_en_i2c;       prev_addr = ifm_rd_addr_i2c;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == rst_at + 1) break;
    end
    start = 1'b0; hold = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_assert++; if (ifm_rd_en_i2c !== '0) begin n_fail++; $display("FAIL reset_rd_en: got %h want 0", ifm_rd_en_i2c); end
    n_assert++; if (ifm_rd_addr_i2c !== '0) begin n_fail++; $display("FAIL reset_rd_addr: got %h want 0", ifm_rd_addr_i2c); end
    n_assert++; if ({col_valid, col_last, busy, done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {col_valid, col_last, busy, done}); end
    n_assert++; if (col_data !== '0 || col_lane_mask !== '0) begin n_fail++; $display("FAIL reset_col: got mask %h, data nonzero=%0d want 0", col_lane_mask, col_data != '0); end
    prev_en = '0;
    rst = 1'b0;
  endtask

  task automatic test_basic_k3();
    run_layer(4, 4, 3, 1, 0, 999, 0, 999, 999);
    n_assert++; if (bz_log[0] !== 1'b0 || bz_log[1] !== 1'b1) begin n_fail++; $display("FAIL k3_busy_start: got %b%b want 01", bz_log[0], bz_log[1]); end
    n_assert++; if (rd_log[1] !== 8'h03) begin n_fail++; $display("FAIL k3_first_rden: got %h want 03", rd_log[1]); end
    n_assert++; if (addr_at(1, 0) != 0 || addr_at(1, 1) != 1 || addr_at(1, 2) != 0) begin n_fail++; $display("FAIL k3_first_addr: got %0d %0d %0d want 0 1 0", addr_at(1, 0), addr_at(1, 1), addr_at(1, 2)); end
    n_assert++; if (addr_at(10, 0) != 4) begin n_fail++; $display("FAIL k3_row1_addr: got %0d want 4", addr_at(10, 0)); end
    n_assert++; if (addr_at(18, 0) != 14 || addr_at(18, 1) != 15) begin n_fail++; $display("FAIL k3_last_addr: got %0d %0d want 14 15", addr_at(18, 0), addr_at(18, 1)); end
    n_assert++; if (count_rd() != 18 || count_cv() != 18) begin n_fail++; $display("FAIL k3_issue_count: got rd %0d valid %0d want 18 18", count_rd(), count_cv()); end
    n_assert++; if (cv_log[2] !== 1'b0 || cv_log[3] !== 1'b1 || cm_log[3] !== 8'h03) begin n_fail++; $display("FAIL k3_first_col: got v%b%b mask %h want v01 mask 03", cv_log[2], cv_log[3], cm_log[3]); end
    n_assert++; if (data_at(3, 1) !== pix(1, 1) || data_at(3, 2) !== '0) begin n_fail++; $display("FAIL k3_first_data: got %h %h want %h 0", data_at(3, 1), data_at(3, 2), pix(1, 1)); end
    n_assert++; if (done_cyc != 20 || cl_log[20] !== 1'b1 || cl_log[19] !== 1'b0 || cv_log[20] !== 1'b1) begin n_fail++; $display("FAIL k3_last_done: got done@%0d last %b%b want done@20 last 01", done_cyc, cl_log[19], cl_log[20]); end
  endtask

  task automatic test_row_k1();
    run_layer(10, 1, 1, 1, 0, 999, 0, 999, 999);
    n_assert++; if (rd_log[1] !== 8'hFF || rd_log[2] !== 8'h03) begin n_fail++; $display("FAIL k1_rden: got %h %h want ff 03", rd_log[1], rd_log[2]); end
    n_assert++; if (addr_at(1, 0) != 0 || addr_at(1, 7) != 7 || addr_at(2, 0) != 8 || addr_at(2, 1) != 9 || addr_at(2, 2) != 0) begin n_fail++; $display("FAIL k1_addr: got %0d %0d %0d %0d %0d want 0 7 8 9 0", addr_at(1, 0), addr_at(1, 7), addr_at(2, 0), addr_at(2, 1), addr_at(2, 2)); end
    n_assert++; if (cm_log[3] !== 8'hFF || cm_log[4] !== 8'h03 || cl_log[3] !== 1'b0 || cl_log[4] !== 1'b1) begin n_fail++; $display("FAIL k1_mask_last: got %h %h last %b%b want ff 03 last 01", cm_log[3], cm_log[4], cl_log[3], cl_log[4]); end
    n_assert++; if (data_at(4, 1) !== pix(1, 9) || data_at(4, 2) !== '0 || data_at(4, 7) !== '0 || data_at(3, 7) !== pix(7, 7)) begin n_fail++; $display("FAIL k1_data: got %h %h %h want %h 0 0", data_at(4, 1), data_at(4, 2), data_at(4, 7), pix(1, 9)); end
    n_assert++; if (done_cyc != 4) begin n_fail++; $display("FAIL k1_done: got %0d want 4", done_cyc); end
  endtask

  task automatic test_stride2();
    run_layer(5, 5, 3, 2, 0, 999, 0, 999, 999);
    n_assert++; if (rd_log[1] !== 8'h03 || addr_at(1, 1) != 2) begin n_fail++; $display("FAIL s2_first: got rden %h addr %0d want 03 2", rd_log[1], addr_at(1, 1)); end
    n_assert++; if (addr_at(18, 1) != 24 || addr_at(18, 0) != 22) begin n_fail++; $display("FAIL s2_last: got %0d %0d want 22 24", addr_at(18, 0), addr_at(18, 1)); end
    n_assert++; if (count_cv() != 18 || done_cyc != 20) begin n_fail++; $display("FAIL s2_count_done: got %0d done@%0d want 18 done@20", count_cv(), done_cyc); end
  endtask

  task automatic test_hold();
    run_layer(4, 4, 3, 1, 0, 5, 3, 999, 999);
    n_assert++; if (rd_log[5] !== '0 || rd_log[6] !== '0 || rd_log[7] !== '0) begin n_fail++; $display("FAIL hold_rden: got %h %h %h want 0 0 0", rd_log[5], rd_log[6], rd_log[7]); end
    n_assert++; if (addr_at(4, 0) != 4 || addr_at(8, 0) != 5) begin n_fail++; $display("FAIL hold_resume: got %0d %0d want 4 5", addr_at(4, 0), addr_at(8, 0)); end
    n_assert++; if (cv_log[9] !== 1'b0 || cv_log[10] !== 1'b1 || data_at(10, 0) !== pix(0, 5)) begin n_fail++; $display("FAIL hold_col: got v%b%b data %h want v01 %h", cv_log[9], cv_log[10], data_at(10, 0), pix(0, 5)); end
    n_assert++; if (count_cv() != 18 || addr_at(21, 1) != 15 || done_cyc != 23) begin n_fail++; $display("FAIL hold_total: got %0d last %0d done@%0d want 18 15 done@23", count_cv(), addr_at(21, 1), done_cyc); end
  endtask

  task automatic test_invalid();
    run_layer(4, 4, 5, 1, 0, 999, 0, 999, 999);
    n_assert++; if (done_cyc != 1 || bz_log[1] !== 1'b1) begin n_fail++; $display("FAIL bad_k_done: got done@%0d busy %b want done@1 busy 1", done_cyc, bz_log[1]); end
    n_assert++; if (count_rd() != 0 || count_cv() != 0) begin n_fail++; $display("FAIL bad_k_quiet: got rd %0d valid %0d want 0 0", count_rd(), count_cv()); end
    run_layer(4, 4, 3, 0, 0, 999, 0, 999, 999);
    n_assert++; if (bz_log[0] !== 1'b0 || done_cyc != 1 || count_rd() != 0) begin n_fail++; $display("FAIL bad_s_done: got busy0 %b done@%0d rd %0d want 0 1 0", bz_log[0], done_cyc, count_rd()); end
  endtask

  task automatic test_start_while_busy();
    run_layer(4, 4, 3, 1, 0, 999, 0, 5, 999);
    n_assert++; if (count_cv() != 18 || addr_at(18, 1) != 15 || done_cyc != 20) begin n_fail++; $display("FAIL busy_start: got %0d last %0d done@%0d want 18 15 done@20", count_cv(), addr_at(18, 1), done_cyc); end
  endtask

  task automatic test_back_to_back();
    run_layer(10, 1, 1, 1, 0, 999, 0, 999, 999);
    run_layer(10, 1, 1, 1, 0, 999, 0, 999, 999);
    n_assert++; if (bz_log[0] !== 1'b0 || rd_log[1] !== 8'hFF || done_cyc != 4) begin n_fail++; $display("FAIL b2b: got busy0 %b rden %h done@%0d want 0 ff 4", bz_log[0], rd_log[1], done_cyc); end
  endtask

`ifdef I2C_PAD_EN
  task automatic test_pad();
    run_layer(3, 3, 3, 1, 1, 999, 0, 999, 10);
    n_assert++; if (rd_log[1] !== '0 || cv_log[3] !== 1'b1 || cm_log[3] !== 8'h07 || cd_log[3] !== '0) begin n_fail++; $display("FAIL pad_first: got rden %h v %b mask %h want 00 1 07", rd_log[1], cv_log[3], cm_log[3]); end
    n_assert++; if (rd_log[4] !== 8'h06 || addr_at(4, 1) != 0 || addr_at(4, 2) != 1 || addr_at(4, 0) != 0) begin n_fail++; $display("FAIL pad_issue3: got %h %0d %0d want 06 0 1", rd_log[4], addr_at(4, 1), addr_at(4, 2)); end
    n_assert++; if (cv_log[10] !== 1'b1) begin n_fail++; $display("FAIL pad_running: got %b want 1", cv_log[10]); end
    n_assert++; if (rd_log[11] !== '0 || ad_log[11] !== '0 || {cv_log[11], cl_log[11], dn_log[11], bz_log[11]} !== 4'b0 || cm_log[11] !== '0 || cd_log[11] !== '0) begin n_fail++; $display("FAIL pad_rst: got rden %h flags %b%b%b%b want 0", rd_log[11], cv_log[11], cl_log[11], dn_log[11], bz_log[11]); end
    prev_en = '0;
  endtask
`else
  task automatic test_pad();
    run_layer(4, 4, 3, 1, 1, 999, 0, 999, 999);
    n_assert++; if (rd_log[1] !== 8'h03 || addr_at(1, 1) != 1 || count_cv() != 18 || done_cyc != 20) begin n_fail++; $display("FAIL pad_ignored: got %h %0d %0d done@%0d want 03 1 18 20", rd_log[1], addr_at(1, 1), count_cv(), done_cyc); end
  endtask
`endif

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    cfg_iw = '0; cfg_ih = '0; cfg_k = '0; cfg_s = '0; cfg_pad = 1'b0;
    pixel_2_i2c = '1; prev_en = '0; prev_addr = '0;
    test_reset();
    test_basic_k3();
    test_row_k1();
    test_stride2();
    test_hold();
    test_invalid();
    test_start_while_busy();
    test_back_to_back();
    test_pad();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
